seg7_scan: RTL and testbench
============================

# seg7_scan

Time-multiplexed driver for the board's 4-digit common-cathode seven-segment display. It sits downstream of counters and test logic. It accepts a 16-bit hex value plus decimal points over a valid/ready handshake and applies new values only at frame boundaries, so the display never tears. It scans the digits with an anti-ghosting guard cycle, applies 16-level brightness PWM, and drives the SEG/COMM pins directly.

## Interface
- DIGIT_CYCLES, 12000: clocks per digit slot (1 ms at 12 MHz, 250 Hz frame); must be a multiple of 16, ≥ 32
- CLK  in  1  12 MHz board clock, all logic on rising edge
- RST_N  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- DATA  in  16  hex value; DATA[3:0] → digit 0 (COMM[0], rightmost)
- DP  in  4  decimal point per digit, DP[i] → digit i
- VALID  in  1  DATA/DP offered
- READY  out  1  block can accept a new value
- BRIGHT  in  4  brightness, 0 = 1/16 on-time, 15 = full
- SEG  out  7  segments a..g = SEG[0]..SEG[6], active high
- DP_OUT  out  1  decimal point segment, active high
- COMM  out  4  digit cathodes, active low
- FRAME  out  1  one-cycle pulse at each frame boundary

## Operation
- Registers: displayed value (16 b + 4 b DP), pending value plus pending flag, digit index (2 b), slot counter 0..DIGIT_CYCLES-1.
- Handshake: transfer occurs when VALID && READY. READY = !pending.
- A transfer outside a boundary cycle sets pending. The pending value loads into the displayed register on the next boundary cycle, which clears pending.
- A transfer on a boundary cycle loads the displayed register directly. Pending stays 0 and READY stays 1.
- A VALID held while READY=0 is ignored; the offered data is not captured.
- Boundary cycle: slot counter = DIGIT_CYCLES-1 and digit index = 3. FRAME = 1 on the following cycle.
- Scan: the slot counter wraps to 0 and increments the digit index, which wraps 3 → 0.
- Guard: on slot count 0 of every digit, COMM = 4'b1111. SEG/DP_OUT take the new digit's pattern.
- PWM: sub-slot = slot count / (DIGIT_CYCLES/16), range 0..15. The digit's cathode is low while slot count ≠ 0 and sub-slot ≤ BRIGHT.
- BRIGHT is sampled every cycle; a change takes effect immediately.
- Decode: hex 0–F to standard segment patterns. a–F include A, b, C, d, E, F.
- Only one COMM bit may be low at any time.

## Timing
- Reset values: SEG = 0, DP_OUT = 0, COMM = 4'b1111, READY = 1, FRAME = 0, displayed value 0, pending 0, digit index 0, slot counter 0.
- All outputs are registered. COMM/SEG reflect the digit index and slot count with one-cycle latency.
- After reset release, digit 0 is guarded at cycle 1 and lit from cycle 2 at BRIGHT = 15.
- Worst-case accept-to-display latency is 4·DIGIT_CYCLES + 1 clocks.
- A reset asserted mid-frame forces reset values immediately; any pending value is discarded.

## Configuration
- SEG7_LEADING_ZERO_BLANK_EN defined:
  - Digits 3..1 whose nibble is 0 and that are more significant than the highest nonzero nibble keep COMM high for the whole slot.
  - A digit with DP set is never blanked.
  - Digit 0 is never blanked.
- Undefined: all four digits are always shown.

## Structure
- Package seg7_pkg holds:
  - NUM_DIGITS = 4
  - the 16-entry hex-to-segment constant table
  - COMM_OFF = 4'b1111
- Sub-module seg7_hex_decode: combinational, 4-bit nibble in, 7-bit segment pattern out. It is instantiated once on the muxed nibble.

## Test plan
- Reset, then VALID with DATA = 16'h1234, DP = 0, BRIGHT = 15 → digits 0..3 show patterns for 4, 3, 2, 1. COMM cycles 1110, 1101, 1011, 0111, each preceded by one 1111 guard cycle.
- Transfer DATA = 16'hABCD mid-frame → READY = 0 until the boundary. Display changes only in the frame after the next FRAME pulse, then READY = 1.
- Second VALID with 16'hFFFF while READY = 0 → ignored; the pending 16'hABCD is displayed.
- VALID coinciding with the boundary cycle → loaded directly, READY never drops.
- BRIGHT = 0, DIGIT_CYCLES = 32 → each cathode is low exactly 1 cycle (sub-slot 0 minus the guard cycle) per 32. BRIGHT = 7 → low 15 cycles.
- With SEG7_LEADING_ZERO_BLANK_EN, DATA = 16'h0050 → digits 3 and 2 are never lit. DATA = 16'h0000 → only digit 0 is lit, showing 0. DP = 4'b1000 with DATA = 16'h0001 → digit 3 is lit.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: digit count,
// cathode idle pattern and the hex-to-segment table (a..g = bit 0..6).
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [NUM_DIGITS-1:0] COMM_OFF = 4'b1111;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment pattern (active high, a = bit 0).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/seg7_scan.sv
// 4-digit multiplexed seven-segment driver with frame-aligned updates,
// guard slot and 16-level PWM. Optional: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYCLES = 12000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           data,
  input  logic [3:0]            dp,
  input  logic                  valid,
  output logic                  ready,
  input  logic [3:0]            bright,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic [NUM_DIGITS-1:0] comm,
  output logic                  frame
);

  localparam int SLOT_W = $clog2(DIGIT_CYCLES);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGIT_CYCLES - 1);
  localparam logic [SLOT_W-1:0] SUB_STEP  = SLOT_W'(DIGIT_CYCLES / 16);

  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [1:0]            digit_q, digit_d;
  logic [15:0]           disp_q, disp_d;
  logic [3:0]            disp_dp_q, disp_dp_d;
  logic                  pend_q, pend_d;
  logic [15:0]           pend_val_q, pend_val_d;
  logic [3:0]            pend_dp_q, pend_dp_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_out_q, dp_out_d;
  logic [NUM_DIGITS-1:0] comm_q, comm_d;
  logic                  frame_q, frame_d;

  logic              boundary;
  logic              accept;
  logic [3:0]        nibble;
  logic [6:0]        nibble_seg;
  logic [SLOT_W-1:0] sub_slot;
  logic              blank;
  logic              lit;

  assign boundary = (slot_q == SLOT_LAST) && (digit_q == 2'(NUM_DIGITS - 1));
  assign accept   = valid && !pend_q;
  assign nibble   = disp_q[{digit_q, 2'b00} +: 4];
  assign sub_slot = slot_q / SUB_STEP;

  seg7_hex_decode u_decode (
    .nibble (nibble),
    .seg    (nibble_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  // A digit is dark when it and everything above it is zero, unless its DP is on.
  always_comb begin
    blank = 1'b0;
    case (digit_q)
      2'd3:    blank = (disp_q[15:12] == 4'h0) && !disp_dp_q[3];
      2'd2:    blank = (disp_q[15:8] == 8'h00) && !disp_dp_q[2];
      2'd1:    blank = (disp_q[15:4] == 12'h000) && !disp_dp_q[1];
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  assign lit = (slot_q != '0) && (sub_slot <= SLOT_W'(bright)) && !blank;

  // Scan counters and the frame-aligned display/pending registers.
  always_comb begin
    slot_d     = slot_q;
    digit_d    = digit_q;
    disp_d     = disp_q;
    disp_dp_d  = disp_dp_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;

    if (slot_q == SLOT_LAST) begin
      slot_d  = '0;
      digit_d = digit_q + 2'd1;
    end else begin
      slot_d = slot_q + SLOT_W'(1);
    end

    if (boundary) begin
      if (pend_q) begin
        disp_d    = pend_val_q;
        disp_dp_d = pend_dp_q;
        pend_d    = 1'b0;
      end else if (accept) begin
        disp_d    = data;
        disp_dp_d = dp;
      end
    end else if (accept) begin
      pend_d     = 1'b1;
      pend_val_d = data;
      pend_dp_d  = dp;
    end
  end

  always_comb begin
    comm_d   = COMM_OFF;
    seg_d    = nibble_seg;
    dp_out_d = disp_dp_q[digit_q];
    frame_d  = boundary;
    if (lit) begin
      comm_d[digit_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q     <= '0;
      digit_q    <= 2'd0;
      disp_q     <= 16'h0000;
      disp_dp_q  <= 4'h0;
      pend_q     <= 1'b0;
      pend_val_q <= 16'h0000;
      pend_dp_q  <= 4'h0;
      seg_q      <= 7'h00;
      dp_out_q   <= 1'b0;
      comm_q     <= COMM_OFF;
      frame_q    <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      digit_q    <= digit_d;
      disp_q     <= disp_d;
      disp_dp_q  <= disp_dp_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      seg_q      <= seg_d;
      dp_out_q   <= dp_out_d;
      comm_q     <= comm_d;
      frame_q    <= frame_d;
    end
  end

  assign ready  = !pend_q;
  assign seg    = seg_q;
  assign dp_out = dp_out_q;
  assign comm   = comm_q;
  assign frame  = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed self-checking bench for seg7_scan with a short 32-clock digit slot.
module tb_seg7_scan;

  localparam int DC = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        valid;
  logic        ready;
  logic [3:0]  bright;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  comm;
  logic        frame;

  int checks = 0;
  int fails  = 0;

  seg7_scan #(.DIGIT_CYCLES(DC)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data   (data),
    .dp     (dp),
    .valid  (valid),
    .ready  (ready),
    .bright (bright),
    .seg    (seg),
    .dp_out (dp_out),
    .comm   (comm),
    .frame  (frame)
  );

  always #5 clk = ~clk;

  // Returns on the falling edge where FRAME is seen high.
  task automatic wait_frame(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (frame !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame !== 1'b1) begin
      fails++;
      $display("[TB] FAIL %s frame_timeout: frame=%b required 1", name, frame);
    end
  endtask

  // Samples one full frame starting right after the FRAME pulse.
  task automatic scan_frame(input string name,
                            input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0,
                            input logic [3:0] dpx,
                            input int l3, input int l2, input int l1, input int l0);
    logic [6:0] exp_seg [4];
    int exp_lit [4];
    int lit_cnt [4];
    int seg_bad [4];
    int dp_bad [4];
    int guard_bad [4];
    int stray;
    exp_seg = '{s0, s1, s2, s3};
    exp_lit = '{l0, l1, l2, l3};
    lit_cnt = '{0, 0, 0, 0};
    seg_bad = '{0, 0, 0, 0};
    dp_bad = '{0, 0, 0, 0};
    guard_bad = '{0, 0, 0, 0};
    stray = 0;
    for (int j = 0; j < 4 * DC; j++) begin
      int d;
      int s;
      logic [3:0] on;
      @(negedge clk);
      d = j / DC;
      s = j % DC;
      on = 4'b1111;
      on[d] = 1'b0;
      if (seg !== exp_seg[d]) seg_bad[d]++;
      if (dp_out !== dpx[d]) dp_bad[d]++;
      if (s == 0 && comm !== 4'b1111) guard_bad[d]++;
      if (comm === on) lit_cnt[d]++;
      else if (comm !== 4'b1111) stray++;
    end
    for (int d = 0; d < 4; d++) begin
      if (exp_lit[d] >= 0) begin
        checks++;
        if (lit_cnt[d] !== exp_lit[d]) begin
          fails++;
          $display("[TB] FAIL %s lit_d%0d: got %0d cycles, required %0d", name, d, lit_cnt[d], exp_lit[d]);
        end
      end
      checks++;
      if (seg_bad[d] !== 0) begin
        fails++;
        $display("[TB] FAIL %s seg_d%0d: %0d wrong samples, required 0 (pattern %h)", name, d, seg_bad[d], exp_seg[d]);
      end
      checks++;
      if (dp_bad[d] !== 0) begin
        fails++;
        $display("[TB] FAIL %s dp_d%0d: %0d wrong samples, required 0", name, d, dp_bad[d]);
      end
      checks++;
      if (guard_bad[d] !== 0) begin
        fails++;
        $display("[TB] FAIL %s guard_d%0d: %0d bad guard slots, required 0", name, d, guard_bad[d]);
      end
    end
    checks++;
    if (stray !== 0) begin
      fails++;
      $display("[TB] FAIL %s stray_comm: %0d bad cathode samples, required 0", name, stray);
    end
  endtask

  task automatic send(input logic [15:0] v, input logic [3:0] p);
    data  = v;
    dp    = p;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks += 5;
    if (seg !== 7'h00) begin fails++; $display("[TB] FAIL rst_seg: got %h required 00", seg); end
    if (dp_out !== 1'b0) begin fails++; $display("[TB] FAIL rst_dp: got %b required 0", dp_out); end
    if (comm !== 4'hF) begin fails++; $display("[TB] FAIL rst_comm: got %b required 1111", comm); end
    if (ready !== 1'b1) begin fails++; $display("[TB] FAIL rst_ready: got %b required 1", ready); end
    if (frame !== 1'b0) begin fails++; $display("[TB] FAIL rst_frame: got %b required 0", frame); end
    rst_n = 1'b1;
    @(negedge clk);
    checks += 2;
    if (comm !== 4'hF) begin fails++; $display("[TB] FAIL first_guard_comm: got %b required 1111", comm); end
    if (seg !== 7'h3F) begin fails++; $display("[TB] FAIL first_guard_seg: got %h required 3f", seg); end
    @(negedge clk);
    checks++;
    if (comm !== 4'b1110) begin fails++; $display("[TB] FAIL first_lit_comm: got %b required 1110", comm); end
  endtask

  task automatic test_basic_scan;
    checks++;
    if (ready !== 1'b1) begin fails++; $display("[TB] FAIL basic_ready_pre: got %b required 1", ready); end
    send(16'h1234, 4'h0);
    checks++;
    if (ready !== 1'b0) begin fails++; $display("[TB] FAIL basic_ready_pend: got %b required 0", ready); end
    wait_frame("basic");
    checks++;
    if (ready !== 1'b1) begin fails++; $display("[TB] FAIL basic_ready_post: got %b required 1", ready); end
    scan_frame("basic_1234", 7'h06, 7'h5B, 7'h4F, 7'h66, 4'h0, 31, 31, 31, 31);
  endtask

  task automatic test_pending_ignore;
    repeat (3) @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin fails++; $display("[TB] FAIL pend_ready_pre: got %b required 1", ready); end
    data  = 16'hABCD;
    dp    = 4'h0;
    valid = 1'b1;
    @(negedge clk);
    data = 16'hFFFF;
    checks++;
    if (ready !== 1'b0) begin fails++; $display("[TB] FAIL pend_ready_low: got %b required 0", ready); end
    repeat (40) @(negedge clk);
    valid = 1'b0;
    checks += 2;
    if (seg !== 7'h4F) begin fails++; $display("[TB] FAIL pend_no_tear: got %h required 4f", seg); end
    if (ready !== 1'b0) begin fails++; $display("[TB] FAIL pend_ready_hold: got %b required 0", ready); end
    wait_frame("pending");
    checks++;
    if (ready !== 1'b1) begin fails++; $display("[TB] FAIL pend_ready_post: got %b required 1", ready); end
    scan_frame("pending_abcd", 7'h77, 7'h7C, 7'h39, 7'h5E, 4'h0, 31, 31, 31, 31);
  endtask

  task automatic test_back_to_back;
    repeat (127) @(negedge clk);
    data  = 16'h5678;
    dp    = 4'h0;
    valid = 1'b1;
    checks++;
    if (ready !== 1'b1) begin fails++; $display("[TB] FAIL bnd_ready_pre: got %b required 1", ready); end
    @(negedge clk);
    valid = 1'b0;
    checks += 2;
    if (ready !== 1'b1) begin fails++; $display("[TB] FAIL bnd_ready_post: got %b required 1", ready); end
    if (frame !== 1'b1) begin fails++; $display("[TB] FAIL bnd_frame: got %b required 1", frame); end
    scan_frame("boundary_5678", 7'h6D, 7'h7D, 7'h07, 7'h7F, 4'h0, 31, 31, 31, 31);
  endtask

  task automatic test_brightness;
    bright = 4'd0;
    wait_frame("bright0");
    scan_frame("bright0", 7'h6D, 7'h7D, 7'h07, 7'h7F, 4'h0, 1, 1, 1, 1);
    bright = 4'd7;
    wait_frame("bright7");
    scan_frame("bright7", 7'h6D, 7'h7D, 7'h07, 7'h7F, 4'h0, 15, 15, 15, 15);
    bright = 4'd15;
  endtask

  task automatic test_dp;
    @(negedge clk);
    send(16'h1234, 4'b0101);
    wait_frame("dp");
    scan_frame("dp_0101", 7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0101, 31, 31, 31, 31);
  endtask

  task automatic test_blank;
    @(negedge clk);
    send(16'h0050, 4'h0);
    wait_frame("blank0050");
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    scan_frame("blank_0050", 7'h3F, 7'h3F, 7'h6D, 7'h3F, 4'h0, 0, 0, 31, 31);
`else
    scan_frame("show_0050", 7'h3F, 7'h3F, 7'h6D, 7'h3F, 4'h0, 31, 31, 31, 31);
`endif
    @(negedge clk);
    send(16'h0000, 4'h0);
    wait_frame("blank0000");
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    scan_frame("blank_0000", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'h0, 0, 0, 0, 31);
`else
    scan_frame("show_0000", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'h0, 31, 31, 31, 31);
`endif
    @(negedge clk);
    send(16'h0001, 4'b1000);
    wait_frame("blankdp");
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    scan_frame("blank_dp3", 7'h3F, 7'h3F, 7'h3F, 7'h06, 4'b1000, 31, -1, -1, 31);
`else
    scan_frame("show_dp3", 7'h3F, 7'h3F, 7'h3F, 7'h06, 4'b1000, 31, 31, 31, 31);
`endif
  endtask

  task automatic test_reset_midframe;
    repeat (10) @(negedge clk);
    send(16'h9999, 4'hF);
    checks++;
    if (ready !== 1'b0) begin fails++; $display("[TB] FAIL mid_ready_pend: got %b required 0", ready); end
    #2 rst_n = 1'b0;
    #1;
    checks += 5;
    if (seg !== 7'h00) begin fails++; $display("[TB] FAIL mid_rst_seg: got %h required 00", seg); end
    if (dp_out !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_dp: got %b required 0", dp_out); end
    if (comm !== 4'hF) begin fails++; $display("[TB] FAIL mid_rst_comm: got %b required 1111", comm); end
    if (ready !== 1'b1) begin fails++; $display("[TB] FAIL mid_rst_ready: got %b required 1", ready); end
    if (frame !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_frame: got %b required 0", frame); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks += 2;
    if (comm !== 4'hF) begin fails++; $display("[TB] FAIL mid_guard_comm: got %b required 1111", comm); end
    if (seg !== 7'h3F) begin fails++; $display("[TB] FAIL mid_guard_seg: got %h required 3f", seg); end
    @(negedge clk);
    checks++;
    if (comm !== 4'b1110) begin fails++; $display("[TB] FAIL mid_lit_comm: got %b required 1110", comm); end
    wait_frame("midreset");
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    scan_frame("mid_discard", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'h0, 0, 0, 0, 31);
`else
    scan_frame("mid_discard", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'h0, 31, 31, 31, 31);
`endif
  endtask

  initial begin
    rst_n  = 1'b0;
    valid  = 1'b0;
    data   = 16'h0000;
    dp     = 4'h0;
    bright = 4'd15;
    test_reset;
    test_basic_scan;
    test_pending_ignore;
    test_back_to_back;
    test_brightness;
    test_dp;
    test_blank;
    test_reset_midframe;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
